// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu_pipe5 pipeline.
//   - opcode encodings, instruction field positions, NOP encoding
//   - register-index width and decoded instruction struct
//   - opcode classification helpers used by hazard and writeback logic
//   - built-in default program image (word i at bits [32*i +: 32])
package cpu_pkg;

    localparam int INSTR_W   = 32;
    localparam int REG_IDX_W = 2;
    localparam int NUM_REGS  = 4;

    // Instruction field bit positions
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 28;
    localparam int RD_HI  = 27;
    localparam int RD_LO  = 26;
    localparam int RS1_HI = 25;
    localparam int RS1_LO = 24;
    localparam int RS2_HI = 23;
    localparam int RS2_LO = 22;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LI   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_LW   = 4'd4;
    localparam logic [3:0] OP_SW   = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [3:0]           op;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [15:0]          imm;
    } instr_t;

    // LI r1,5; LI r2,7; ADD r3,r1,r2; SW r3,[r0+0]; SW r1,[r0+1]; HALT
    localparam logic [INSTR_W*16-1:0] DEFAULT_PROG = {
        {10{32'h0000_0000}},
        32'h6000_0000,
        32'h5040_0001,
        32'h50C0_0000,
        32'h2D80_0000,
        32'h1800_0007,
        32'h1400_0005
    };

    function automatic logic writes_rd(input logic [3:0] op);
        return (op == OP_LI) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_LW);
    endfunction

    function automatic logic reads_rs1(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic reads_rs2(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: 4 x WIDTH register file for cpu_pipe5.
//   clk, rst           : clock, asynchronous active-high reset (all regs -> 0)
//   rs1_addr/rs1_data  : asynchronous read port 1
//   rs2_addr/rs2_data  : asynchronous read port 2
//   wr_en/wr_addr/wr_data : write port, committed on the rising edge
// r0 always reads 0; writes to r0 are dropped. Reads are write-through: a read
// of the register being written this cycle returns the incoming value.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_addr,
    input  logic [REG_IDX_W-1:0] rs2_addr,
    output logic [WIDTH-1:0]     rs1_data,
    output logic [WIDTH-1:0]     rs2_data,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic             wr_live;

    // regs_q[0] is never written, so it stays at its reset value of 0.
    assign wr_live = wr_en && (wr_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        rs1_data = (wr_live && (wr_addr == rs1_addr)) ? wr_data : regs_q[rs1_addr];
        rs2_data = (wr_live && (wr_addr == rs2_addr)) ? wr_data : regs_q[rs2_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/cpu_pipe5.sv
// cpu_pipe5: self-contained 5-stage in-order CPU
//   (fetch, decode/reg-read, execute, memory, writeback).
//   clk : single clock, all state updates on the rising edge
//   rst : asynchronous active-high reset
// Program ROM (PROG_IMAGE parameter, word i at [32*i +: 32]), register file and
// MEM_SIZE-word data memory are internal. Observable internals: hit (stall),
// opcode_step_2..opcode_step_5 (opcode in each stage), mem_flat (data memory,
// word i at [WIDTH*(MEM_SIZE-i)-1 -: WIDTH]).
// Optional feature macro FORWARDING_EN: bypass stage-3/4 results into stage-2
// operands; only load-use then stalls. Undefined: every RAW hazard stalls.
module cpu_pipe5
    import cpu_pkg::*;
#(
    parameter int                          WIDTH      = 32,
    parameter int                          MEM_SIZE   = 32,
    parameter int                          ROM_SIZE   = 16,
    parameter logic [INSTR_W*ROM_SIZE-1:0] PROG_IMAGE = DEFAULT_PROG
) (
    input logic clk,
    input logic rst
);

    localparam int PC_W   = $clog2(ROM_SIZE);
    localparam int MEM_AW = $clog2(MEM_SIZE);

    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 halt_q, halt_d;
    instr_t               s2_q, s2_d;
    logic [3:0]           op_3_q, op_3_d, op_4_q, op_4_d, op_5_q, op_5_d;
    logic [REG_IDX_W-1:0] rd_3_q, rd_3_d, rd_4_q, rd_4_d, rd_5_q, rd_5_d;
    logic [WIDTH-1:0]     a_3_q, a_3_d, b_3_q, b_3_d, imm_3_q, imm_3_d;
    logic [WIDTH-1:0]     res_4_q, res_4_d, st_4_q, st_4_d, res_5_q, res_5_d;
    logic [MEM_AW-1:0]    addr_4_q, addr_4_d;
    logic [WIDTH-1:0]     mem_q [MEM_SIZE];
    logic [WIDTH-1:0]     mem_d [MEM_SIZE];
    logic [WIDTH*MEM_SIZE-1:0] mem_flat;

    logic                 hit;
    logic [3:0]           opcode_step_2, opcode_step_3, opcode_step_4, opcode_step_5;

    logic [INSTR_W-1:0]   rom_word;
    instr_t               fetch_instr;
    logic                 unused_rom_bits;
    logic [WIDTH-1:0]     rf_rd1, rf_rd2, opnd_a, opnd_b;
    logic [WIDTH-1:0]     alu_3, wb_4, mem_rd_4, imm_ext_2;
    logic [MEM_AW-1:0]    addr_3;
    logic                 use_rs1, use_rs2;

    assign opcode_step_2 = s2_q.op;
    assign opcode_step_3 = op_3_q;
    assign opcode_step_4 = op_4_q;
    assign opcode_step_5 = op_5_q;

    for (genvar gi = 0; gi < MEM_SIZE; gi++) begin : g_flat
        assign mem_flat[WIDTH*(MEM_SIZE-gi)-1 -: WIDTH] = mem_q[gi];
    end

    cpu_regfile #(.WIDTH(WIDTH)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (s2_q.rs1),
        .rs2_addr (s2_q.rs2),
        .rs1_data (rf_rd1),
        .rs2_data (rf_rd2),
        .wr_en    (writes_rd(opcode_step_5)),
        .wr_addr  (rd_5_q),
        .wr_data  (res_5_q)
    );

    // Fetch and decode (field slicing only)
    always_comb begin
        rom_word        = PROG_IMAGE[INSTR_W*pc_q +: INSTR_W];
        fetch_instr     = '{op:  rom_word[OP_HI:OP_LO],   rd:  rom_word[RD_HI:RD_LO],
                            rs1: rom_word[RS1_HI:RS1_LO], rs2: rom_word[RS2_HI:RS2_LO],
                            imm: rom_word[IMM_HI:IMM_LO]};
        unused_rom_bits = ^rom_word[RS2_LO-1:IMM_HI+1];
        imm_ext_2       = {{(WIDTH-16){s2_q.imm[15]}}, s2_q.imm};
        use_rs1         = reads_rs1(opcode_step_2) && (s2_q.rs1 != '0);
        use_rs2         = reads_rs2(opcode_step_2) && (s2_q.rs2 != '0);
    end

    // Execute and memory-stage values
    always_comb begin
        case (op_3_q)
            OP_LI:   alu_3 = imm_3_q;
            OP_ADD:  alu_3 = a_3_q + b_3_q;
            OP_SUB:  alu_3 = a_3_q - b_3_q;
            default: alu_3 = '0;
        endcase
        addr_3   = MEM_AW'((a_3_q + imm_3_q) % WIDTH'(MEM_SIZE));
        mem_rd_4 = mem_flat[WIDTH*(MEM_SIZE-int'(addr_4_q))-1 -: WIDTH];
        wb_4     = (op_4_q == OP_LW) ? mem_rd_4 : res_4_q;
    end

    // Hazard detection and operand selection. Stage 5 needs no handling here
    // because the register file is write-through.
`ifdef FORWARDING_EN
    always_comb begin
        hit = (op_3_q == OP_LW) && (rd_3_q != '0) &&
              ((use_rs1 && (s2_q.rs1 == rd_3_q)) || (use_rs2 && (s2_q.rs2 == rd_3_q)));
        // A stage-3 LW match is covered by hit; its bubble discards these operands.
        opnd_a = rf_rd1;
        if (writes_rd(op_3_q) && (rd_3_q != '0) && (rd_3_q == s2_q.rs1)) begin
            opnd_a = alu_3;
        end else if (writes_rd(op_4_q) && (rd_4_q != '0) && (rd_4_q == s2_q.rs1)) begin
            opnd_a = wb_4;
        end
        opnd_b = rf_rd2;
        if (writes_rd(op_3_q) && (rd_3_q != '0) && (rd_3_q == s2_q.rs2)) begin
            opnd_b = alu_3;
        end else if (writes_rd(op_4_q) && (rd_4_q != '0) && (rd_4_q == s2_q.rs2)) begin
            opnd_b = wb_4;
        end
    end
`else
    always_comb begin
        hit = (use_rs1 && ((writes_rd(op_3_q) && (rd_3_q == s2_q.rs1)) ||
                           (writes_rd(op_4_q) && (rd_4_q == s2_q.rs1)))) ||
              (use_rs2 && ((writes_rd(op_3_q) && (rd_3_q == s2_q.rs2)) ||
                           (writes_rd(op_4_q) && (rd_4_q == s2_q.rs2))));
        opnd_a = rf_rd1;
        opnd_b = rf_rd2;
    end
`endif

    // Next-state for all pipeline registers
    always_comb begin
        pc_d    = pc_q;
        s2_d    = s2_q;
        halt_d  = halt_q || (opcode_step_2 == OP_HALT);
        op_3_d  = OP_NOP;
        rd_3_d  = '0;
        a_3_d   = '0;
        b_3_d   = '0;
        imm_3_d = '0;
        if (!hit) begin
            op_3_d  = s2_q.op;
            rd_3_d  = s2_q.rd;
            a_3_d   = opnd_a;
            b_3_d   = opnd_b;
            imm_3_d = imm_ext_2;
            // Once HALT leaves stage 2 the PC is frozen and fetch feeds NOPs.
            if (halt_d) begin
                s2_d = NOP_INSTR;
            end else begin
                s2_d = fetch_instr;
                pc_d = (pc_q == PC_W'(ROM_SIZE - 1)) ? '0 : pc_q + 1'b1;
            end
        end
        op_4_d   = op_3_q;
        rd_4_d   = rd_3_q;
        res_4_d  = alu_3;
        st_4_d   = b_3_q;
        addr_4_d = addr_3;
        op_5_d   = op_4_q;
        rd_5_d   = rd_4_q;
        res_5_d  = wb_4;
        mem_d    = mem_q;
        if (op_4_q == OP_SW) begin
            mem_d[addr_4_q] = st_4_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            halt_q   <= 1'b0;
            s2_q     <= NOP_INSTR;
            op_3_q   <= OP_NOP;
            rd_3_q   <= '0;
            a_3_q    <= '0;
            b_3_q    <= '0;
            imm_3_q  <= '0;
            op_4_q   <= OP_NOP;
            rd_4_q   <= '0;
            res_4_q  <= '0;
            st_4_q   <= '0;
            addr_4_q <= '0;
            op_5_q   <= OP_NOP;
            rd_5_q   <= '0;
            res_5_q  <= '0;
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            halt_q   <= halt_d;
            s2_q     <= s2_d;
            op_3_q   <= op_3_d;
            rd_3_q   <= rd_3_d;
            a_3_q    <= a_3_d;
            b_3_q    <= b_3_d;
            imm_3_q  <= imm_3_d;
            op_4_q   <= op_4_d;
            rd_4_q   <= rd_4_d;
            res_4_q  <= res_4_d;
            st_4_q   <= st_4_d;
            addr_4_q <= addr_4_d;
            op_5_q   <= op_5_d;
            rd_5_q   <= rd_5_d;
            res_5_q  <= res_5_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_cpu_pipe5.sv
// tb_cpu_pipe5: directed bench for cpu_pipe5.
// Three instances run three programs: the built-in default, a SUB wrap-around
// program and a memory address wrap / load-use program. The default instance
// is also reset once after halting and once in the middle of a stall.
module tb_cpu_pipe5;
    import cpu_pkg::*;

    // LI r1,9; (opcode 15 with rd=r3: must act as NOP); SUB r2,r0,r1; HALT
    localparam logic [511:0] PROG_SUB = {
        {12{32'h0000_0000}},
        32'h6000_0000, 32'h3840_0000, 32'hFC00_0005, 32'h1400_0009
    };
    // LI r1,0x8001; SW r1,[r0+33]; LW r2,[r0+1]; ADD r3,r2,r2; HALT
    localparam logic [511:0] PROG_WRAP = {
        {11{32'h0000_0000}},
        32'h6000_0000, 32'h2E80_0000, 32'h4800_0001, 32'h5040_0021, 32'h1400_8001
    };

`ifdef FORWARDING_EN
    localparam int         EXP_HIT_MAIN = 0;
    localparam int         EXP_HIT_SUB  = 0;
    localparam int         EXP_HIT_WRAP = 1;
    localparam logic [3:0] EXP_OP3_T47  = OP_ADD;
    localparam logic       EXP_HIT_T202 = 1'b0;
`else
    localparam int         EXP_HIT_MAIN = 4;
    localparam int         EXP_HIT_SUB  = 1;
    localparam int         EXP_HIT_WRAP = 4;
    localparam logic [3:0] EXP_OP3_T47  = OP_NOP;
    localparam logic       EXP_HIT_T202 = 1'b1;
`endif

    // Clock / reset: posedges at 10, 20, 30 ... ns
    logic clk = 1'b1;
    logic rst;
    logic rst_b;
    always #5 clk = ~clk;

    cpu_pipe5 dut (
        .clk (clk),
        .rst (rst)
    );
    cpu_pipe5 #(.PROG_IMAGE(PROG_SUB)) dut_sub (
        .clk (clk),
        .rst (rst_b)
    );
    cpu_pipe5 #(.PROG_IMAGE(PROG_WRAP)) dut_wrap (
        .clk (clk),
        .rst (rst_b)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int hit_main = 0;
    int hit_sub = 0;
    int hit_wrap = 0;

    always @(negedge clk) begin
        if (dut.hit)      hit_main <= hit_main + 1;
        if (dut_sub.hit)  hit_sub  <= hit_sub + 1;
        if (dut_wrap.hit) hit_wrap <= hit_wrap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_main_result(input string pfx);
        check({pfx, "_r1"},   dut.u_regfile.regs_q[1], 32'd5);
        check({pfx, "_r2"},   dut.u_regfile.regs_q[2], 32'd7);
        check({pfx, "_r3"},   dut.u_regfile.regs_q[3], 32'd12);
        check({pfx, "_mem0"}, dut.mem_flat[1023 -: 32], 32'd12);
        check({pfx, "_mem1"}, dut.mem_flat[991 -: 32],  32'd5);
        check({pfx, "_op2_halted"}, 32'(dut.opcode_step_2), 32'(OP_NOP));
    endtask

    task automatic check_main_cleared(input string pfx);
        check({pfx, "_r1"},   dut.u_regfile.regs_q[1], 32'd0);
        check({pfx, "_r2"},   dut.u_regfile.regs_q[2], 32'd0);
        check({pfx, "_r3"},   dut.u_regfile.regs_q[3], 32'd0);
        check({pfx, "_mem0"}, dut.mem_flat[1023 -: 32], 32'd0);
        check({pfx, "_mem1"}, dut.mem_flat[991 -: 32],  32'd0);
        check({pfx, "_op2"},  32'(dut.opcode_step_2), 32'd0);
        check({pfx, "_op3"},  32'(dut.opcode_step_3), 32'd0);
        check({pfx, "_op4"},  32'(dut.opcode_step_4), 32'd0);
        check({pfx, "_op5"},  32'(dut.opcode_step_5), 32'd0);
        check({pfx, "_hit"},  32'(dut.hit), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        rst_b = 1'b1;
        #1;
        check("reset_op3", 32'(dut.opcode_step_3), 32'd0);
        check("reset_hit", 32'(dut.hit), 32'd0);
        #4;
        rst   = 1'b0;
        rst_b = 1'b0;

        // t=27: LI r1 has reached stage 3, LI r2 in stage 2 (no hazard)
        #22;
        check("t27_op3_li", 32'(dut.opcode_step_3), 32'(OP_LI));
        check("t27_hit",    32'(dut.hit), 32'd0);

        // t=47: ADD waiting on r2 (bubble) or already in execute when bypassed
        #20;
        check("t47_op3", 32'(dut.opcode_step_3), 32'(EXP_OP3_T47));

        // t=167: all programs finished
        #120;
        check_main_result("main");
        check("main_hits", 32'(hit_main), 32'(EXP_HIT_MAIN));
        check("sub_r1",    dut_sub.u_regfile.regs_q[1], 32'd9);
        check("sub_r2",    dut_sub.u_regfile.regs_q[2], 32'hFFFF_FFF7);
        check("sub_r3_nop_op15", dut_sub.u_regfile.regs_q[3], 32'd0);
        check("sub_hits",  32'(hit_sub), 32'(EXP_HIT_SUB));
        check("wrap_r1",   dut_wrap.u_regfile.regs_q[1], 32'hFFFF_8001);
        check("wrap_mem1", dut_wrap.mem_flat[991 -: 32], 32'hFFFF_8001);
        check("wrap_mem0", dut_wrap.mem_flat[1023 -: 32], 32'd0);
        check("wrap_r2",   dut_wrap.u_regfile.regs_q[2], 32'hFFFF_8001);
        check("wrap_r3",   dut_wrap.u_regfile.regs_q[3], 32'hFFFF_0002);
        check("wrap_hits", 32'(hit_wrap), 32'(EXP_HIT_WRAP));

        // Reset after the program halted: state clears immediately
        #5;
        rst = 1'b1;
        #1;
        check_main_cleared("rst_halted");
        #2;
        rst = 1'b0;

        // t=202: ADD in stage 2 behind LI r2 / LI r1 (stalls without bypass)
        #27;
        check("t202_hit", 32'(dut.hit), 32'(EXP_HIT_T202));
        #1;
        rst = 1'b1;
        #1;
        check("rst_stall_hit", 32'(dut.hit), 32'd0);
        check("rst_stall_op2", 32'(dut.opcode_step_2), 32'd0);
        check("rst_stall_op3", 32'(dut.opcode_step_3), 32'd0);
        check("rst_stall_op4", 32'(dut.opcode_step_4), 32'd0);
        #1;
        rst = 1'b0;

        // t=217: first fetch after reset is PC 0 (LI r1,5)
        #12;
        check("restart_op2", 32'(dut.opcode_step_2), 32'(OP_LI));
        check("restart_op3", 32'(dut.opcode_step_3), 32'(OP_NOP));

        #160;
        check_main_result("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
